// File: rtl/alphatensor_mul_seq.sv
// alphatensor_mul_seq: sequencer for the 4x4 matrix-multiply datapath.
// Takes one request at a time from the IDU. It reads operands A and B from the
// matrix memory, runs the datapath, and writes the result back to rd.
// A speculative op that the BRU flushes never writes memory.
// Optional build macro ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN: when rs1==rs2 the
// sequencer issues a single read and captures that data into both operands.
module alphatensor_mul_seq #(
  parameter int IDX_W  = 4,
  parameter int ELEM_W = 32,
  parameter int N_ELEM = 16,
  parameter int MAT_W  = N_ELEM * ELEM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idu_req_vld,
  output logic             idu_req_rdy,
  input  logic [IDX_W-1:0] idu_rd_idx,
  input  logic [IDX_W-1:0] idu_rs1_idx,
  input  logic [IDX_W-1:0] idu_rs2_idx,
  input  logic             idu_req_spec,
  input  logic             bru_vld,
  input  logic             bru_flush,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_rd_idx,
  input  logic [MAT_W-1:0] mem_rd_data,
  output logic             mem_wr_en,
  output logic [IDX_W-1:0] mem_wr_idx,
  output logic [MAT_W-1:0] mem_wr_data,
  output logic             dp_start,
  output logic             dp_abort,
  output logic [MAT_W-1:0] dp_op_a,
  output logic [MAT_W-1:0] dp_op_b,
  input  logic             dp_done,
  input  logic [MAT_W-1:0] dp_result,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_flushed
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    EXEC,
    HOLD,
    WB
`ifdef ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN
    , CAP_A
`endif
  } state_t;

  state_t           state;
  state_t           stateNxt;

  logic [IDX_W-1:0] rdQ;
  logic [IDX_W-1:0] rs1Q;
  logic [IDX_W-1:0] rs2Q;
  logic             specQ;
  logic             startQ;
  logic [MAT_W-1:0] opA;
  logic [MAT_W-1:0] opB;
  logic [MAT_W-1:0] resQ;

  logic             flushReq;
  logic             resolve;
  logic             specEff;
  logic             accept;
  logic             kill;
  logic             doneOk;

  assign flushReq = bru_vld & bru_flush;
  assign resolve  = bru_vld & ~bru_flush;
  // A resolve arriving this cycle already counts when choosing between HOLD and WB.
  assign specEff  = specQ & ~resolve;
  assign accept   = idu_req_vld & idu_req_rdy;
  // WB never holds a speculative op, so only IDLE is excluded besides WB.
  assign kill     = flushReq & specQ & (state != IDLE) & (state != WB);
  // A done pulse is ignored if it coincides with the start pulse or with a flush.
  assign doneOk   = (state == EXEC) & dp_done & ~startQ & ~kill;

  assign seq_busy = (state != IDLE);
  assign dp_op_a  = opA;
  assign dp_op_b  = opB;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next-state and strobe decode. A flush kill overrides the per-state result.
  always_comb begin
    stateNxt    = state;
    idu_req_rdy = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_idx  = '0;
    mem_wr_en   = 1'b0;
    mem_wr_idx  = '0;
    mem_wr_data = '0;
    dp_start    = 1'b0;
    dp_abort    = 1'b0;
    seq_done    = 1'b0;
    seq_flushed = 1'b0;
    case (state)
      IDLE: begin
        idu_req_rdy = ~flushReq;
        if (accept) stateNxt = RD_A;
      end
      RD_A: begin
        mem_rd_en  = 1'b1;
        mem_rd_idx = rs1Q;
`ifdef ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN
        stateNxt   = (rs1Q == rs2Q) ? CAP_A : RD_B;
`else
        stateNxt   = RD_B;
`endif
      end
      RD_B: begin
        mem_rd_en  = 1'b1;
        mem_rd_idx = rs2Q;
        stateNxt   = CAP_B;
      end
      CAP_B: stateNxt = EXEC;
`ifdef ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN
      CAP_A: stateNxt = EXEC;
`endif
      EXEC: begin
        dp_start = startQ;
        if (doneOk) stateNxt = specEff ? HOLD : WB;
      end
      HOLD: begin
        if (resolve) stateNxt = WB;
      end
      WB: begin
        mem_wr_en   = 1'b1;
        mem_wr_idx  = rdQ;
        mem_wr_data = resQ;
        seq_done    = 1'b1;
        stateNxt    = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    if (kill) begin
      stateNxt    = IDLE;
      seq_flushed = 1'b1;
      dp_abort    = (state == EXEC);
    end
  end

  // Request latch, speculation tracking and first-EXEC-cycle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdQ    <= '0;
      rs1Q   <= '0;
      rs2Q   <= '0;
      specQ  <= 1'b0;
      startQ <= 1'b0;
    end else begin
      if (accept) begin
        rdQ   <= idu_rd_idx;
        rs1Q  <= idu_rs1_idx;
        rs2Q  <= idu_rs2_idx;
        specQ <= idu_req_spec & ~bru_vld;
      end else if (kill) begin
        specQ <= 1'b0;
      end else if ((state != IDLE) && resolve) begin
        specQ <= 1'b0;
      end
      startQ <= (stateNxt == EXEC) && (state != EXEC);
    end
  end

  // Operand capture one cycle after each read strobe, plus result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA  <= '0;
      opB  <= '0;
      resQ <= '0;
    end else begin
      case (state)
        RD_B:  opA <= mem_rd_data;
        CAP_B: opB <= mem_rd_data;
`ifdef ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN
        CAP_A: begin
          opA <= mem_rd_data;
          opB <= mem_rd_data;
        end
`endif
        EXEC:  if (doneOk) resQ <= dp_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alphatensor_mul_seq.sv
// Bench for alphatensor_mul_seq. Directed ops are laid out on an absolute cycle
// timeline. An event-schedule model derives the expected strobes of every cycle
// from the request, BRU and reset timing. The bench also holds a memory model
// and a datapath model with a fixed latency.
`timescale 1ns/1ps
module tb_alphatensor_mul_seq;
  localparam int IDX_W  = 4;
  localparam int ELEM_W = 32;
  localparam int N_ELEM = 16;
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int NCYC   = 100;
  localparam int LAT    = 3;
`ifdef ALPHATENSOR_SEQ_SAME_SRC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             idu_req_vld = 1'b0;
  logic             idu_req_rdy;
  logic [IDX_W-1:0] idu_rd_idx = '0;
  logic [IDX_W-1:0] idu_rs1_idx = '0;
  logic [IDX_W-1:0] idu_rs2_idx = '0;
  logic             idu_req_spec = 1'b0;
  logic             bru_vld = 1'b0;
  logic             bru_flush = 1'b0;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_rd_idx;
  logic [MAT_W-1:0] mem_rd_data;
  logic             mem_wr_en;
  logic [IDX_W-1:0] mem_wr_idx;
  logic [MAT_W-1:0] mem_wr_data;
  logic             dp_start;
  logic             dp_abort;
  logic [MAT_W-1:0] dp_op_a;
  logic [MAT_W-1:0] dp_op_b;
  logic             dp_done;
  logic [MAT_W-1:0] dp_result;
  logic             seq_busy;
  logic             seq_done;
  logic             seq_flushed;

  alphatensor_mul_seq #(
    .IDX_W (IDX_W),
    .ELEM_W(ELEM_W),
    .N_ELEM(N_ELEM),
    .MAT_W (MAT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .idu_req_vld (idu_req_vld),
    .idu_req_rdy (idu_req_rdy),
    .idu_rd_idx  (idu_rd_idx),
    .idu_rs1_idx (idu_rs1_idx),
    .idu_rs2_idx (idu_rs2_idx),
    .idu_req_spec(idu_req_spec),
    .bru_vld     (bru_vld),
    .bru_flush   (bru_flush),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_idx  (mem_rd_idx),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_idx  (mem_wr_idx),
    .mem_wr_data (mem_wr_data),
    .dp_start    (dp_start),
    .dp_abort    (dp_abort),
    .dp_op_a     (dp_op_a),
    .dp_op_b     (dp_op_b),
    .dp_done     (dp_done),
    .dp_result   (dp_result),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .seq_flushed (seq_flushed)
  );

  always #5 clk = ~clk;

  // ---------------- environment: memory and datapath ----------------
  logic [MAT_W-1:0] envMem [16];
  logic [MAT_W-1:0] rdDataQ = '0;
  int               wrCount = 0;
  int               dpCnt = 0;
  logic [31:0]      dpFill = 32'h0;
  logic             stray = 1'b0;

  assign mem_rd_data = rdDataQ;

  always @(posedge clk) begin
    if (mem_rd_en) rdDataQ <= envMem[mem_rd_idx];
    if (mem_wr_en) begin
      envMem[mem_wr_idx] <= mem_wr_data;
      wrCount <= wrCount + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                 dpCnt <= 0;
    else if (dp_abort)       dpCnt <= 0;
    else if (dp_start)       dpCnt <= LAT;
    else if (dpCnt != 0)     dpCnt <= dpCnt - 1;
  end

  assign dp_done   = (dpCnt == 1) || stray;
  assign dp_result = dp_done ? {N_ELEM{dpFill}} : {N_ELEM{~dpFill}};

  // ---------------- stimulus and expectation tables ----------------
  bit               sVld [NCYC];
  logic [IDX_W-1:0] sRd  [NCYC];
  logic [IDX_W-1:0] sRs1 [NCYC];
  logic [IDX_W-1:0] sRs2 [NCYC];
  bit               sSpec[NCYC];
  bit               sBruV[NCYC];
  bit               sBruF[NCYC];
  bit               sRst [NCYC];
  bit               sStray[NCYC];
  logic [31:0]      sFill[NCYC];

  bit               eBusy[NCYC];
  bit               eRdy [NCYC];
  bit               eRdEn[NCYC];
  logic [IDX_W-1:0] eRdIdx[NCYC];
  bit               eStart[NCYC];
  logic [MAT_W-1:0] eOpA [NCYC];
  logic [MAT_W-1:0] eOpB [NCYC];
  bit               eAbort[NCYC];
  bit               eWrEn[NCYC];
  logic [IDX_W-1:0] eWrIdx[NCYC];
  logic [MAT_W-1:0] eWrData[NCYC];
  bit               eFlushed[NCYC];
  bit               eRst [NCYC];
  logic [MAT_W-1:0] expMem [16];
  int               expWrites = 0;

  int cyc = -1;
  int total = 0;
  int bad = 0;

  function automatic logic [MAT_W-1:0] matPat(input int i);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int j = 0; j < N_ELEM; j++) m[j*ELEM_W +: ELEM_W] = 32'hC0DE0000 | 32'(i * 256 + j);
    return m;
  endfunction

  // Expected-event schedule of one op, from its accept cycle and the BRU/reset timeline.
  task automatic planOp(input int acc, input int rd, input int rs1, input int rs2,
                        input bit spec, input int rstC, input logic [31:0] fill);
    bit byp, specLive, flushed, cut;
    int startC, doneC, clearC, wC, flushC, endC;
    byp = BYP && (rs1 == rs2);
    sVld[acc] = 1'b1;
    sRd[acc]  = IDX_W'(rd);
    sRs1[acc] = IDX_W'(rs1);
    sRs2[acc] = IDX_W'(rs2);
    sSpec[acc] = spec;
    for (int c = acc; c < NCYC; c++) sFill[c] = fill;
    startC   = acc + (byp ? 3 : 4);
    doneC    = startC + LAT;
    specLive = spec && !(sBruV[acc] && !sBruF[acc]);
    clearC   = NCYC + 10;
    if (specLive)
      for (int c = NCYC - 1; c > acc; c--) if (sBruV[c] && !sBruF[c]) clearC = c;
    wC = doneC + 1;
    if (specLive && clearC > doneC) wC = clearC + 1;
    flushed = 1'b0;
    flushC  = 0;
    if (specLive)
      for (int c = wC - 1; c > acc; c--)
        if (c < clearC && sBruV[c] && sBruF[c]) begin
          flushed = 1'b1;
          flushC  = c;
        end
    endC = flushed ? flushC : wC;
    cut  = (rstC > 0) && (rstC <= endC);
    if (cut) endC = rstC - 1;
    for (int c = acc + 1; c <= endC; c++) eBusy[c] = 1'b1;
    if (acc + 1 <= endC) begin
      eRdEn[acc + 1]  = 1'b1;
      eRdIdx[acc + 1] = IDX_W'(rs1);
    end
    if (!byp && acc + 2 <= endC) begin
      eRdEn[acc + 2]  = 1'b1;
      eRdIdx[acc + 2] = IDX_W'(rs2);
    end
    if (startC <= endC) begin
      eStart[startC] = 1'b1;
      eOpA[startC]   = expMem[rs1];
      eOpB[startC]   = expMem[rs2];
    end
    if (!cut && flushed) begin
      eFlushed[flushC] = 1'b1;
      eAbort[flushC]   = (flushC >= startC);
    end
    if (!cut && !flushed) begin
      eWrEn[wC]   = 1'b1;
      eWrIdx[wC]  = IDX_W'(rd);
      eWrData[wC] = {N_ELEM{fill}};
      expMem[rd]  = {N_ELEM{fill}};
      expWrites++;
    end
  endtask

  task automatic chk(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc >= 0) begin
      chk("busy",    MAT_W'(seq_busy),    MAT_W'(eBusy[cyc]));
      chk("rdy",     MAT_W'(idu_req_rdy), MAT_W'(eRdy[cyc]));
      chk("rd_en",   MAT_W'(mem_rd_en),   MAT_W'(eRdEn[cyc]));
      chk("wr_en",   MAT_W'(mem_wr_en),   MAT_W'(eWrEn[cyc]));
      chk("start",   MAT_W'(dp_start),    MAT_W'(eStart[cyc]));
      chk("abort",   MAT_W'(dp_abort),    MAT_W'(eAbort[cyc]));
      chk("done",    MAT_W'(seq_done),    MAT_W'(eWrEn[cyc]));
      chk("flushed", MAT_W'(seq_flushed), MAT_W'(eFlushed[cyc]));
      if (eRdEn[cyc]) chk("rd_idx", MAT_W'(mem_rd_idx), MAT_W'(eRdIdx[cyc]));
      if (eWrEn[cyc]) begin
        chk("wr_idx",  MAT_W'(mem_wr_idx), MAT_W'(eWrIdx[cyc]));
        chk("wr_data", mem_wr_data, eWrData[cyc]);
      end
      if (eStart[cyc]) begin
        chk("op_a", dp_op_a, eOpA[cyc]);
        chk("op_b", dp_op_b, eOpB[cyc]);
      end
      if (eRst[cyc]) begin
        chk("rst_op_a",   dp_op_a,     '0);
        chk("rst_op_b",   dp_op_b,     '0);
        chk("rst_wdata",  mem_wr_data, '0);
        chk("rst_rd_idx", MAT_W'(mem_rd_idx), '0);
        chk("rst_wr_idx", MAT_W'(mem_wr_idx), '0);
      end
      // hand-computed pins on the directed timeline
      if (cyc == 4)  chk("pin_rdA",   MAT_W'({mem_rd_en, mem_rd_idx}), MAT_W'({1'b1, 4'd2}));
      if (cyc == 5)  chk("pin_rdB",   MAT_W'({mem_rd_en, mem_rd_idx}), MAT_W'({1'b1, 4'd3}));
      if (cyc == 7)  chk("pin_start", MAT_W'(dp_start), MAT_W'(1));
      if (cyc == 11) begin
        chk("pin_wb",      MAT_W'({mem_wr_en, seq_done, mem_wr_idx}), MAT_W'({1'b1, 1'b1, 4'd1}));
        chk("pin_wb_data", mem_wr_data, {N_ELEM{32'hA5A5A5A5}});
      end
      if (cyc == 12) chk("pin_rdy_after", MAT_W'(idu_req_rdy), MAT_W'(1));
      if (cyc == 24) chk("pin_hold",      MAT_W'({seq_busy, mem_wr_en}), MAT_W'(2'b10));
      if (cyc == 25) chk("pin_late_wb",   MAT_W'(mem_wr_en), MAT_W'(1));
      if (cyc == 33) chk("pin_flush",     MAT_W'({dp_abort, seq_flushed}), MAT_W'(2'b11));
      if (cyc == 34) chk("pin_idle",      MAT_W'(seq_busy), MAT_W'(0));
      if (cyc == 37) chk("pin_rdy_flush", MAT_W'(idu_req_rdy), MAT_W'(0));
      if (cyc == 53) chk("pin_rst",       MAT_W'({seq_busy, idu_req_rdy}), MAT_W'(2'b01));
      if (cyc == (BYP ? 83 : 84)) chk("pin_same_src_wb", MAT_W'(mem_wr_en), MAT_W'(1));
    end
  end

  // ---------------- table build and driver ----------------
  initial begin
    for (int c = 0; c < NCYC; c++) begin
      sVld[c] = 1'b0; sRd[c] = IDX_W'(c); sRs1[c] = IDX_W'(c + 5); sRs2[c] = IDX_W'(c + 9);
      sSpec[c] = 1'b0; sBruV[c] = 1'b0; sBruF[c] = 1'b0; sRst[c] = 1'b0; sStray[c] = 1'b0;
      sFill[c] = 32'h0;
      eBusy[c] = 1'b0; eRdy[c] = 1'b0; eRdEn[c] = 1'b0; eRdIdx[c] = '0; eStart[c] = 1'b0;
      eOpA[c] = '0; eOpB[c] = '0; eAbort[c] = 1'b0; eWrEn[c] = 1'b0; eWrIdx[c] = '0;
      eWrData[c] = '0; eFlushed[c] = 1'b0; eRst[c] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      envMem[i] <= matPat(i);
      expMem[i] = matPat(i);
    end
    // reset windows
    sRst[0] = 1'b1; sRst[1] = 1'b1; sRst[53] = 1'b1;
    eRst[0] = 1'b1; eRst[1] = 1'b1; eRst[53] = 1'b1;
    // BRU timeline
    sBruV[24] = 1'b1;                      // late non-flush resolve of op1
    sBruV[33] = 1'b1; sBruF[33] = 1'b1;    // flush in EXEC of op2
    sBruV[37] = 1'b1; sBruF[37] = 1'b1;    // flush while idle with a request present
    sBruV[73] = 1'b1; sBruF[73] = 1'b1;    // flush coincident with dp_done of op6
    sBruV[76] = 1'b1;                      // same-cycle resolve at op7 accept
    sBruV[90] = 1'b1;                      // early resolve of op8
    sBruV[93] = 1'b1; sBruF[93] = 1'b1;    // flush after resolve: ignored
    // stray done pulses: coincident with a start, and while idle after a flush
    sStray[7] = 1'b1; sStray[35] = 1'b1;
    // request refused at 37 then accepted at 38
    sVld[37] = 1'b1; sRd[37] = 4'd4; sRs1[37] = 4'd1; sRs2[37] = 4'd2;
    //     acc rd rs1 rs2 spec rstC fill
    planOp( 3, 1, 2, 3, 1'b0,  0, 32'hA5A5A5A5);
    planOp(14, 1, 2, 3, 1'b1,  0, 32'h11223344);
    planOp(28, 5, 2, 3, 1'b1,  0, 32'hDEADBEEF);
    planOp(38, 4, 1, 2, 1'b0,  0, 32'h5A5A0F0F);
    planOp(48, 5, 2, 3, 1'b0, 53, 32'h77777777);
    planOp(56, 2, 2, 3, 1'b0,  0, 32'h0F1E2D3C);
    planOp(66, 7, 2, 6, 1'b1,  0, 32'h66666666);
    planOp(76, 8, 3, 3, 1'b1,  0, 32'h13579BDF);
    planOp(88, 9, 4, 1, 1'b1,  0, 32'h2468ACE0);
    for (int c = 0; c < NCYC; c++) eRdy[c] = !eBusy[c] && !(sBruV[c] && sBruF[c]);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc          = c;
      rst          = sRst[c];
      idu_req_vld  = sVld[c];
      idu_rd_idx   = sRd[c];
      idu_rs1_idx  = sRs1[c];
      idu_rs2_idx  = sRs2[c];
      idu_req_spec = sSpec[c];
      bru_vld      = sBruV[c];
      bru_flush    = sBruF[c];
      stray        = sStray[c];
      dpFill       = sFill[c];
    end
    @(negedge clk);
    #1;
    chk("write_count", MAT_W'(wrCount), MAT_W'(expWrites));
    chk("write_count_pin", MAT_W'(wrCount), MAT_W'(6));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
